// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard controller: forward-select codes,
// Tnew/Tuse constants, the per-stage shadow record, and the match/select rules.
package hazard_pkg;

  localparam int unsigned HZ_REG_W  = 5;
  localparam int unsigned HZ_TIME_W = 2;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10,
    FWD_E  = 2'b11
  } fwd_sel_e;

  localparam logic [HZ_TIME_W-1:0] TNEW_JAL  = HZ_TIME_W'(0);
  localparam logic [HZ_TIME_W-1:0] TNEW_ALU  = HZ_TIME_W'(1);
  localparam logic [HZ_TIME_W-1:0] TNEW_LOAD = HZ_TIME_W'(2);
  localparam logic [HZ_TIME_W-1:0] TUSE_NONE = HZ_TIME_W'(3);

  typedef struct packed {
    logic [HZ_REG_W-1:0]  WriteReg;
    logic                 RegWrite;
    logic [HZ_TIME_W-1:0] Tnew;
    logic [HZ_REG_W-1:0]  rs;
    logic [HZ_REG_W-1:0]  rt;
  } hz_stage_t;

  // $0 is hard-wired zero, so a write to it never produces a usable value.
  function automatic logic hz_match(hz_stage_t s, logic [HZ_REG_W-1:0] r);
    return (r != '0) && s.RegWrite && (s.WriteReg == r);
  endfunction

  function automatic logic hz_src_stall(logic [HZ_REG_W-1:0]  r,
                                        logic [HZ_TIME_W-1:0] tuse,
                                        hz_stage_t            e,
                                        hz_stage_t            m);
    return (hz_match(e, r) && (tuse < e.Tnew)) ||
           (hz_match(m, r) && (tuse < m.Tnew));
  endfunction

  function automatic fwd_sel_e hz_fwd_d(logic [HZ_REG_W-1:0] r,
                                        hz_stage_t e,
                                        hz_stage_t m,
                                        hz_stage_t w);
    if (hz_match(e, r) && (e.Tnew == '0)) return FWD_E;
    if (hz_match(m, r) && (m.Tnew == '0)) return FWD_M;
    if (hz_match(w, r))                   return FWD_W;
    return FWD_RF;
  endfunction

  function automatic fwd_sel_e hz_fwd_e(logic [HZ_REG_W-1:0] r,
                                        hz_stage_t m,
                                        hz_stage_t w);
    if (hz_match(m, r)) return FWD_M;
    if (hz_match(w, r)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage operand/destination info and the stall/forward controls exchanged
// between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W  = HZ_REG_W,
  parameter int unsigned TIME_W = HZ_TIME_W
);

  logic [REG_W-1:0]  rsD;
  logic [REG_W-1:0]  rtD;
  logic [TIME_W-1:0] TuseRsD;
  logic [TIME_W-1:0] TuseRtD;
  logic [REG_W-1:0]  WriteRegD;
  logic              RegWriteD;
  logic [TIME_W-1:0] TnewD;
  logic              MdUseD;
  logic              MdBusyE;

  logic              StallF;
  logic              StallD;
  logic              FlushE;
  logic [1:0]        ForwardAD;
  logic [1:0]        ForwardBD;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              ForwardBM;

  modport master (
    output rsD, rtD, TuseRsD, TuseRtD, WriteRegD, RegWriteD, TnewD, MdUseD, MdBusyE,
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE, ForwardBM
  );

  modport slave (
    input  rsD, rtD, TuseRsD, TuseRtD, WriteRegD, RegWriteD, TnewD, MdUseD, MdBusyE,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE, ForwardBM
  );

endinterface

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage shadow of {WriteReg, RegWrite, Tnew, rs, rt} with
// synchronous clear, bubble insertion and optional saturating Tnew decrement.
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter bit DEC_TNEW = 1'b1
) (
  input  logic      clk_i,
  input  logic      clear_i,
  input  logic      bubble_i,
  input  hz_stage_t stage_i,
  output hz_stage_t stage_o
);

  hz_stage_t stage_d;
  hz_stage_t stage_q;

  always_comb begin
    stage_d = stage_i;
    if (DEC_TNEW && (stage_i.Tnew != '0)) begin
      stage_d.Tnew = stage_i.Tnew - HZ_TIME_W'(1);
    end
    if (bubble_i) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: tracks E/M/W writers,
// stalls D on Tuse/Tnew conflicts or busy mult/div, and selects forwards.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  hz_stage_t stage_dec;
  hz_stage_t stage_e;
  hz_stage_t stage_m;
  hz_stage_t stage_w;
  logic      stall;
  logic      md_stall;
  logic      data_stall;
  logic      unused_fields;

  assign stage_dec = '{
    WriteReg: hz.WriteRegD,
    RegWrite: hz.RegWriteD,
    Tnew:     hz.TnewD,
    rs:       hz.rsD,
    rt:       hz.rtD
  };

  // E receives the raw D Tnew; decrements happen on the E->M and M->W moves,
  // so each shadow's Tnew is already the remaining latency at that stage.
  hazard_stage_reg #(.DEC_TNEW(1'b0)) u_stage_e (
    .clk_i    (clk),
    .clear_i  (reset),
    .bubble_i (stall),
    .stage_i  (stage_dec),
    .stage_o  (stage_e)
  );

  hazard_stage_reg #(.DEC_TNEW(1'b1)) u_stage_m (
    .clk_i    (clk),
    .clear_i  (reset),
    .bubble_i (1'b0),
    .stage_i  (stage_e),
    .stage_o  (stage_m)
  );

  hazard_stage_reg #(.DEC_TNEW(1'b1)) u_stage_w (
    .clk_i    (clk),
    .clear_i  (reset),
    .bubble_i (1'b0),
    .stage_i  (stage_m),
    .stage_o  (stage_w)
  );

  // Both causes collapse into one stall signal, so they never stack bubbles.
  assign md_stall   = hz.MdUseD && hz.MdBusyE;
  assign data_stall = hz_src_stall(hz.rsD, hz.TuseRsD, stage_e, stage_m) ||
                      hz_src_stall(hz.rtD, hz.TuseRtD, stage_e, stage_m);
  assign stall      = md_stall || data_stall;

  assign hz.StallF = stall;
  assign hz.StallD = stall;
  assign hz.FlushE = stall;

  assign hz.ForwardAD = hz_fwd_d(hz.rsD, stage_e, stage_m, stage_w);
  assign hz.ForwardBD = hz_fwd_d(hz.rtD, stage_e, stage_m, stage_w);
  assign hz.ForwardAE = hz_fwd_e(stage_e.rs, stage_m, stage_w);
  assign hz.ForwardBE = hz_fwd_e(stage_e.rt, stage_m, stage_w);
  assign hz.ForwardBM = hz_match(stage_w, stage_m.rt);

  assign unused_fields = ^{stage_m.rs, stage_w.rs, stage_w.rt, stage_w.Tnew};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against an in-flight
// instruction model that derives each stage's remaining Tnew from its age.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model of in-flight instructions: index 0 = E, 1 = M, 2 = W.
  // tn0 is the Tnew the instruction had when it entered E.
  int p_wr[3], p_rw[3], p_tn0[3], p_rs[3], p_rt[3];

  int d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr, d_rw, d_tnew, d_mduse, d_mdbusy;
  int last_stall, last_fad, last_fbd, last_fae, last_fbe, last_fbm;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int remaining(int k);
    int t;
    t = p_tn0[k] - k;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit hit(int k, int r);
    return (r != 0) && (p_rw[k] != 0) && (p_wr[k] == r);
  endfunction

  function automatic bit exp_stall();
    bit s;
    s = (d_mduse != 0) && (d_mdbusy != 0);
    for (int k = 0; k < 2; k++) begin
      if (hit(k, d_rs) && (d_tuse_rs < remaining(k))) s = 1'b1;
      if (hit(k, d_rt) && (d_tuse_rt < remaining(k))) s = 1'b1;
    end
    return s;
  endfunction

  function automatic int exp_fwd_d(int r);
    if (hit(0, r) && remaining(0) == 0) return 3;
    if (hit(1, r) && remaining(1) == 0) return 2;
    if (hit(2, r)) return 1;
    return 0;
  endfunction

  function automatic int exp_fwd_e(int r);
    if (hit(1, r)) return 2;
    if (hit(2, r)) return 1;
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      p_wr[k] = 0; p_rw[k] = 0; p_tn0[k] = 0; p_rs[k] = 0; p_rt[k] = 0;
    end
  endtask

  task automatic drive();
    hz.rsD       = 5'(d_rs);
    hz.rtD       = 5'(d_rt);
    hz.TuseRsD   = 2'(d_tuse_rs);
    hz.TuseRtD   = 2'(d_tuse_rt);
    hz.WriteRegD = 5'(d_wr);
    hz.RegWriteD = (d_rw != 0);
    hz.TnewD     = 2'(d_tnew);
    hz.MdUseD    = (d_mduse != 0);
    hz.MdBusyE   = (d_mdbusy != 0);
  endtask

  task automatic set_d(input int rs, input int rt, input int urs, input int urt,
                       input int wr, input int rw, input int tnew, input int mduse);
    d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt;
    d_wr = wr; d_rw = rw; d_tnew = tnew; d_mduse = mduse; d_mdbusy = 0;
    drive();
  endtask

  task automatic set_idle();
    set_d(0, 0, 3, 3, 0, 0, 0, 0);
  endtask

  // One clock: compare at negedge, advance the model, return just after posedge.
  task automatic step(output bit s_o);
    bit s;
    drive();
    @(negedge clk);
    s = exp_stall();
    last_stall = hz.StallF ? 1 : 0;
    last_fad = hz.ForwardAD; last_fbd = hz.ForwardBD;
    last_fae = hz.ForwardAE; last_fbe = hz.ForwardBE;
    last_fbm = hz.ForwardBM ? 1 : 0;
    chk("stall3", {hz.StallF, hz.StallD, hz.FlushE}, s ? 7 : 0);
    chk("fwdAD", last_fad, exp_fwd_d(d_rs));
    chk("fwdBD", last_fbd, exp_fwd_d(d_rt));
    chk("fwdAE", last_fae, exp_fwd_e(p_rs[0]));
    chk("fwdBE", last_fbe, exp_fwd_e(p_rt[0]));
    chk("fwdBM", last_fbm, hit(2, p_rt[1]) ? 1 : 0);
    if (reset) begin
      model_clear();
    end else begin
      for (int k = 2; k > 0; k--) begin
        p_wr[k] = p_wr[k-1]; p_rw[k] = p_rw[k-1]; p_tn0[k] = p_tn0[k-1];
        p_rs[k] = p_rs[k-1]; p_rt[k] = p_rt[k-1];
      end
      if (s) begin
        p_wr[0] = 0; p_rw[0] = 0; p_tn0[0] = 0; p_rs[0] = 0; p_rt[0] = 0;
      end else begin
        p_wr[0] = d_wr; p_rw[0] = d_rw; p_tn0[0] = d_tnew;
        p_rs[0] = d_rs; p_rt[0] = d_rt;
      end
    end
    s_o = s;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_free(input int max_cyc, output int n_stall);
    bit s;
    n_stall = 0;
    for (int i = 0; i < max_cyc; i++) begin
      step(s);
      if (!s) return;
      n_stall++;
    end
  endtask

  initial begin
    bit s;
    int n;
    reset = 1'b1;
    set_idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset: everything zero.
    for (int i = 0; i < 5; i++) begin
      step(s);
      chk("rst_idle_stall", last_stall, 0);
    end

    // lw $8 then addu $9,$8,$1.
    set_d(29, 8, 1, 3, 8, 1, 2, 0);
    step(s);
    set_d(8, 1, 1, 1, 9, 1, 1, 0);
    run_until_free(8, n);
    chk("ld_use_stalls", n, 1);
    set_idle();
    #1;
    chk("ld_use_fwdAE", hz.ForwardAE, int'(FWD_W));
    step(s);

    // addu $3 then beq $3,$0.
    set_d(1, 2, 1, 1, 3, 1, 1, 0);
    step(s);
    set_d(3, 0, 0, 0, 0, 0, 0, 0);
    run_until_free(8, n);
    chk("alu_br_stalls", n, 1);
    chk("alu_br_fwdAD", last_fad, 2);
    set_idle();
    repeat (3) step(s);

    // jal then a D-stage reader of $31.
    set_d(0, 0, 3, 3, 31, 1, 0, 0);
    step(s);
    set_d(31, 0, 0, 3, 0, 0, 0, 0);
    step(s);
    chk("jal_nostall", last_stall, 0);
    chk("jal_fwdAD", last_fad, 3);
    set_idle();
    repeat (3) step(s);

    // Writer to $0 followed by a reader of $0.
    set_d(1, 2, 1, 1, 0, 1, 1, 0);
    step(s);
    set_d(0, 0, 0, 0, 4, 1, 1, 0);
    step(s);
    chk("r0_nostall", last_stall, 0);
    chk("r0_fwd", last_fad + last_fbd, 0);
    set_idle();
    repeat (3) step(s);

    // Mult/div busy window, with and without a D-stage MD user.
    for (int u = 1; u >= 0; u--) begin
      set_d(0, 0, 3, 3, 0, 0, 0, u);
      n = 0;
      for (int i = 0; i < 7; i++) begin
        d_mdbusy = (i < 5) ? 1 : 0;
        step(s);
        n += last_stall;
      end
      chk(u ? "md_stall5" : "md_nouse", n, u ? 5 : 0);
    end
    set_idle();
    repeat (3) step(s);

    // Reset asserted while a load-use stall is pending.
    set_d(29, 8, 1, 3, 8, 1, 2, 0);
    step(s);
    set_d(8, 1, 1, 1, 9, 1, 1, 0);
    reset = 1'b1;
    step(s);
    reset = 1'b0;
    step(s);
    chk("rst_mid_stall", last_stall, 0);
    set_idle();
    repeat (2) step(s);

    // Random instruction stream; D inputs are held while stalled.
    s = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!s) begin
        d_rs      = $urandom_range(0, 4);
        d_rt      = $urandom_range(0, 4);
        d_tuse_rs = $urandom_range(0, 2);
        d_tuse_rt = $urandom_range(0, 3);
        d_wr      = $urandom_range(0, 4);
        d_rw      = $urandom_range(0, 1);
        d_tnew    = $urandom_range(0, 2);
        d_mduse   = ($urandom_range(0, 7) == 0) ? 1 : 0;
      end
      d_mdbusy = ($urandom_range(0, 3) == 0) ? 1 : 0;
      reset = ($urandom_range(0, 49) == 0);
      step(s);
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
